// File: rtl/pc_branch_unit_if.sv
// Bus between the ALU/decode side and the PC/branch stage.
// The slave modport is the PC stage's view; master is the driver's view.
interface pc_branch_unit_if #(
   parameter int unsigned PC_W  = 10,
   parameter int unsigned OFF_W = 8
) ();
   logic [2:0]       ALUop;
   logic             equalFlag;
   logic             lessThanFlag;
   logic             flagValid;
   logic             brReq;
   logic [1:0]       brCond;
   logic             brAbs;
   logic [OFF_W-1:0] brOffset;
   logic [PC_W-1:0]  brTarget;
   logic             stall;
   logic             halt;
   logic [PC_W-1:0]  PC;
   logic             fetchEn;
   logic             flagEQ;
   logic             flagLT;
   logic             taken;
   logic             halted;

   modport slave (
      input  ALUop, equalFlag, lessThanFlag, flagValid, brReq, brCond, brAbs,
             brOffset, brTarget, stall, halt,
      output PC, fetchEn, flagEQ, flagLT, taken, halted
   );

   modport master (
      output ALUop, equalFlag, lessThanFlag, flagValid, brReq, brCond, brAbs,
             brOffset, brTarget, stall, halt,
      input  PC, fetchEn, flagEQ, flagLT, taken, halted
   );
endinterface

// File: rtl/pc_branch_unit.sv
// Program counter, flag register and branch resolution behind the 8-bit ALU.
// Define FLAG_BYPASS_EN to let a same-cycle flag write feed the branch condition.
module pc_branch_unit #(
   parameter int unsigned     PC_W     = 10,
   parameter int unsigned     OFF_W    = 8,
   parameter logic [PC_W-1:0] RESET_PC = '0
) (
   input logic             CLK,
   input logic             RST_N,
   pc_branch_unit_if.slave bus
);

   typedef enum logic [1:0] {StBoot, StRun, StHalt} state_e;

   state_e          state_q, state_d;
   logic [PC_W-1:0] pc_q, pc_d;
   logic            flag_eq_q, flag_eq_d;
   logic            flag_lt_q, flag_lt_d;
   logic            taken_q, taken_d;
   logic            fetch_en_q, fetch_en_d;
   logic            halted_q, halted_d;

   logic            eq_write, lt_write;
   logic            cond_eq, cond_lt, cond_ok;
   logic [PC_W-1:0] off_ext;

   always_comb begin
      eq_write = bus.flagValid && (bus.ALUop == 3'd5);
      lt_write = bus.flagValid && (bus.ALUop == 3'd6);
`ifdef FLAG_BYPASS_EN
      cond_eq  = eq_write ? bus.equalFlag : flag_eq_q;
      cond_lt  = lt_write ? bus.lessThanFlag : flag_lt_q;
`else
      cond_eq  = flag_eq_q;
      cond_lt  = flag_lt_q;
`endif
      case (bus.brCond)
         2'b00:   cond_ok = 1'b1;
         2'b01:   cond_ok = cond_eq;
         2'b10:   cond_ok = cond_lt;
         default: cond_ok = !cond_eq;
      endcase
      // Signed cast sign-extends the offset; the add then wraps modulo 2^PC_W.
      off_ext = PC_W'($signed(bus.brOffset));
   end

   always_comb begin
      state_d   = state_q;
      pc_d      = pc_q;
      flag_eq_d = flag_eq_q;
      flag_lt_d = flag_lt_q;
      taken_d   = 1'b0;
      unique case (state_q)
         StBoot: state_d = StRun;
         StRun: begin
            if (bus.halt) begin
               state_d = StHalt;
            end else if (!bus.stall) begin
               if (eq_write) flag_eq_d = bus.equalFlag;
               if (lt_write) flag_lt_d = bus.lessThanFlag;
               if (bus.brReq && cond_ok) begin
                  pc_d    = bus.brAbs ? bus.brTarget : pc_q + off_ext;
                  taken_d = 1'b1;
               end else begin
                  pc_d = pc_q + PC_W'(1);
               end
            end
         end
         StHalt: state_d = StHalt;
         default: state_d = StBoot;
      endcase
      fetch_en_d = (state_d == StRun);
      halted_d   = (state_d == StHalt);
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state_q    <= StBoot;
         pc_q       <= RESET_PC;
         flag_eq_q  <= 1'b0;
         flag_lt_q  <= 1'b0;
         taken_q    <= 1'b0;
         fetch_en_q <= 1'b0;
         halted_q   <= 1'b0;
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         flag_eq_q  <= flag_eq_d;
         flag_lt_q  <= flag_lt_d;
         taken_q    <= taken_d;
         fetch_en_q <= fetch_en_d;
         halted_q   <= halted_d;
      end
   end

   assign bus.PC      = pc_q;
   assign bus.fetchEn = fetch_en_q;
   assign bus.flagEQ  = flag_eq_q;
   assign bus.flagLT  = flag_lt_q;
   assign bus.taken   = taken_q;
   assign bus.halted  = halted_q;

endmodule

// File: tb/tb_pc_branch_unit.sv
// Directed vector bench for pc_branch_unit; expectations follow FLAG_BYPASS_EN.
module tb_pc_branch_unit;

   logic CLK;
   logic RST_N;

   pc_branch_unit_if #(.PC_W(10), .OFF_W(8)) bus ();

   pc_branch_unit #(.PC_W(10), .OFF_W(8), .RESET_PC(10'd0)) dut (
      .CLK   (CLK),
      .RST_N (RST_N),
      .bus   (bus)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   typedef struct {
      logic [2:0] aluop;
      logic       eqf;
      logic       ltf;
      logic       fv;
      logic       br;
      logic [1:0] cond;
      logic       abs;
      logic [7:0] off;
      logic [9:0] tgt;
      logic       stall;
      logic       halt;
      logic [9:0] e_pc;
      logic       e_eq;
      logic       e_lt;
      logic       e_taken;
      logic       e_fe;
      logic       e_halted;
   } vec_t;

   vec_t vecs[27];
   int   total = 0;
   int   bad   = 0;

   task automatic chk(input string name, input int idx, input int act, input int exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s [%0d]: got %0d expected %0d", name, idx, act, exp);
      end
   endtask

   task automatic check_outs(input int idx, input int pc, input int eq, input int lt,
                             input int tk, input int fe, input int hl);
      chk("PC", idx, int'(bus.PC), pc);
      chk("flagEQ", idx, int'(bus.flagEQ), eq);
      chk("flagLT", idx, int'(bus.flagLT), lt);
      chk("taken", idx, int'(bus.taken), tk);
      chk("fetchEn", idx, int'(bus.fetchEn), fe);
      chk("halted", idx, int'(bus.halted), hl);
   endtask

   task automatic drive(input vec_t v);
      bus.ALUop        = v.aluop;
      bus.equalFlag    = v.eqf;
      bus.lessThanFlag = v.ltf;
      bus.flagValid    = v.fv;
      bus.brReq        = v.br;
      bus.brCond       = v.cond;
      bus.brAbs        = v.abs;
      bus.brOffset     = v.off;
      bus.brTarget     = v.tgt;
      bus.stall        = v.stall;
      bus.halt         = v.halt;
   endtask

   // Args: aluop eqf ltf fv br cond abs off tgt stall halt | pc eq lt taken fe halted
   function automatic vec_t mk(input logic [2:0] aluop, input logic eqf, input logic ltf,
                               input logic fv, input logic br, input logic [1:0] cond,
                               input logic abs, input logic [7:0] off, input logic [9:0] tgt,
                               input logic stall, input logic halt, input logic [9:0] e_pc,
                               input logic e_eq, input logic e_lt, input logic e_taken,
                               input logic e_fe, input logic e_halted);
      vec_t v;
      v.aluop = aluop; v.eqf = eqf; v.ltf = ltf; v.fv = fv; v.br = br; v.cond = cond;
      v.abs = abs; v.off = off; v.tgt = tgt; v.stall = stall; v.halt = halt;
      v.e_pc = e_pc; v.e_eq = e_eq; v.e_lt = e_lt; v.e_taken = e_taken;
      v.e_fe = e_fe; v.e_halted = e_halted;
      return v;
   endfunction

   initial begin
      // Boot edge holds PC, then sequential fetch.
      vecs[0]  = mk(0, 0, 0, 0, 0, 0, 0, 8'h00, 0,   0, 0,    0, 0, 0, 0, 1, 0);
      vecs[1]  = mk(0, 0, 0, 0, 0, 0, 0, 8'h00, 0,   0, 0,    1, 0, 0, 0, 1, 0);
      vecs[2]  = mk(0, 0, 0, 0, 0, 0, 0, 8'h00, 0,   0, 0,    2, 0, 0, 0, 1, 0);
      vecs[3]  = mk(0, 0, 0, 0, 0, 0, 0, 8'h00, 0,   0, 0,    3, 0, 0, 0, 1, 0);
      // Set EQ, then branch -2 on EQ from PC 5.
      vecs[4]  = mk(5, 1, 0, 1, 0, 0, 0, 8'h00, 0,   0, 0,    4, 1, 0, 0, 1, 0);
      vecs[5]  = mk(0, 0, 0, 0, 0, 0, 0, 8'h00, 0,   0, 0,    5, 1, 0, 0, 1, 0);
      vecs[6]  = mk(0, 0, 0, 0, 1, 1, 0, 8'hFE, 0,   0, 0,    3, 1, 0, 1, 1, 0);
      vecs[7]  = mk(0, 0, 0, 0, 0, 0, 0, 8'h00, 0,   0, 0,    4, 1, 0, 0, 1, 0);
      // LT cleared, branch on LT and on NE both fall through.
      vecs[8]  = mk(6, 0, 0, 1, 0, 0, 0, 8'h00, 0,   0, 0,    5, 1, 0, 0, 1, 0);
      vecs[9]  = mk(0, 0, 0, 0, 0, 0, 0, 8'h00, 0,   0, 0,    6, 1, 0, 0, 1, 0);
      vecs[10] = mk(0, 0, 0, 0, 0, 0, 0, 8'h00, 0,   0, 0,    7, 1, 0, 0, 1, 0);
      vecs[11] = mk(0, 0, 0, 0, 1, 2, 0, 8'h05, 0,   0, 0,    8, 1, 0, 0, 1, 0);
      vecs[12] = mk(0, 0, 0, 0, 1, 3, 0, 8'h05, 0,   0, 0,    9, 1, 0, 0, 1, 0);
      // Absolute jump to max, wrap on increment, wrap backwards on -1.
      vecs[13] = mk(0, 0, 0, 0, 1, 0, 1, 8'h00, 1023, 0, 0, 1023, 1, 0, 1, 1, 0);
      vecs[14] = mk(0, 0, 0, 0, 0, 0, 0, 8'h00, 0,   0, 0,    0, 1, 0, 0, 1, 0);
      vecs[15] = mk(0, 0, 0, 0, 1, 0, 0, 8'hFF, 0,   0, 0, 1023, 1, 0, 1, 1, 0);
      vecs[16] = mk(6, 0, 1, 1, 0, 0, 0, 8'h00, 0,   0, 0,    0, 1, 1, 0, 1, 0);
      vecs[17] = mk(0, 0, 0, 0, 1, 2, 0, 8'h10, 0,   0, 0,   16, 1, 1, 1, 1, 0);
      // Non-flag ALU op leaves flags alone.
      vecs[18] = mk(3, 0, 0, 1, 0, 0, 0, 8'h00, 0,   0, 0,   17, 1, 1, 0, 1, 0);
      // Three stalled cycles with a pending branch and flag write.
      vecs[19] = mk(5, 0, 0, 1, 1, 0, 1, 8'h00, 500, 1, 0,   17, 1, 1, 0, 1, 0);
      vecs[20] = mk(5, 0, 0, 1, 1, 0, 1, 8'h00, 500, 1, 0,   17, 1, 1, 0, 1, 0);
      vecs[21] = mk(5, 0, 0, 1, 1, 0, 1, 8'h00, 500, 1, 0,   17, 1, 1, 0, 1, 0);
      vecs[22] = mk(5, 0, 0, 1, 0, 0, 0, 8'h00, 0,   0, 0,   18, 0, 1, 0, 1, 0);
      // Same-cycle EQ write and branch on EQ from PC 18, offset +10.
`ifdef FLAG_BYPASS_EN
      vecs[23] = mk(5, 1, 0, 1, 1, 1, 0, 8'h0A, 0,   0, 0,   28, 1, 1, 1, 1, 0);
      vecs[24] = mk(0, 0, 0, 0, 0, 0, 0, 8'h00, 0,   1, 1,   28, 1, 1, 0, 0, 1);
      vecs[25] = mk(0, 0, 0, 0, 1, 0, 1, 8'h00, 5,   0, 0,   28, 1, 1, 0, 0, 1);
      vecs[26] = mk(5, 0, 0, 1, 0, 0, 0, 8'h00, 0,   0, 0,   28, 1, 1, 0, 0, 1);
`else
      vecs[23] = mk(5, 1, 0, 1, 1, 1, 0, 8'h0A, 0,   0, 0,   19, 1, 1, 0, 1, 0);
      vecs[24] = mk(0, 0, 0, 0, 0, 0, 0, 8'h00, 0,   1, 1,   19, 1, 1, 0, 0, 1);
      vecs[25] = mk(0, 0, 0, 0, 1, 0, 1, 8'h00, 5,   0, 0,   19, 1, 1, 0, 0, 1);
      vecs[26] = mk(5, 0, 0, 1, 0, 0, 0, 8'h00, 0,   0, 0,   19, 1, 1, 0, 0, 1);
`endif

      RST_N = 1'b0;
      drive(mk(0, 0, 0, 0, 0, 0, 0, 8'h00, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      repeat (2) @(posedge CLK);
      #1;
      check_outs(-1, 0, 0, 0, 0, 0, 0);

      @(negedge CLK);
      RST_N = 1'b1;
      for (int i = 0; i < 27; i++) begin
         drive(vecs[i]);
         @(posedge CLK);
         #1;
         check_outs(i, int'(vecs[i].e_pc), int'(vecs[i].e_eq), int'(vecs[i].e_lt),
                    int'(vecs[i].e_taken), int'(vecs[i].e_fe), int'(vecs[i].e_halted));
         @(negedge CLK);
      end

      // Asynchronous reset out of HALT with a branch still requested.
      drive(mk(0, 0, 0, 0, 1, 0, 1, 8'h00, 100, 0, 0, 0, 0, 0, 0, 0, 0));
      #2;
      RST_N = 1'b0;
      #1;
      check_outs(100, 0, 0, 0, 0, 0, 0);
      @(negedge CLK);
      RST_N = 1'b1;
      @(posedge CLK);
      #1;
      check_outs(101, 0, 0, 0, 0, 1, 0);
      @(posedge CLK);
      #1;
      check_outs(102, 100, 0, 0, 1, 1, 0);

      // Async reset asserted mid-RUN, away from any clock edge.
      @(negedge CLK);
      drive(mk(0, 0, 0, 0, 0, 0, 0, 8'h00, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      @(posedge CLK);
      #1;
      check_outs(103, 101, 0, 0, 0, 1, 0);
      #2;
      RST_N = 1'b0;
      #1;
      check_outs(104, 0, 0, 0, 0, 0, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
